// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared word/SRAM widths and FSM state encoding for sram_ctrl.
package sram_ctrl_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int SRAM_DW = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit MEM-stage access split into two 16-bit SRAM halves with pipeline freeze.
// Define SRAM_CTRL_ALIGN_CHECK_EN to flag misaligned word addresses on err during DONE.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [WORD_WIDTH-1:0]  ALU_res,
  input  logic [WORD_WIDTH-1:0]  Val_Rm,
  output logic                   ready,
  output logic [WORD_WIDTH-1:0]  MEM_out,
  output logic                   err,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DW-1:0]     sram_dq_o,
  input  logic [SRAM_DW-1:0]     sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_wr;
  logic [SRAM_ADDR_W-2:0] r_waddr;
  logic [WORD_WIDTH-1:0]  r_data;
  logic [WORD_WIDTH-1:0]  r_mem_out;
  logic [SRAM_ADDR_W-1:0] r_addr_o;
  logic [SRAM_DW-1:0]     r_dq_o;
  logic                   r_oe;
  logic                   r_we_n;
  logic                   w_req;
  logic                   w_last;
  logic [3:0]             w_cnt_nx;
  logic                   w_unused;
  assign w_req    = MEM_R_EN | MEM_W_EN;
  assign w_last   = r_cnt == LAST;
  assign w_cnt_nx = r_cnt + 4'd1;
  assign w_unused = ^ALU_res;
  assign ready      = !((r_state == ST_IDLE && w_req) || r_state == ST_LO || r_state == ST_HI);
  assign MEM_out    = r_mem_out;
  assign sram_addr  = r_addr_o;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_oe;
  assign sram_we_n  = r_we_n;
  // Outputs are registered for the state being entered; we_n releases on each half's last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_wr      <= 1'b0;
      r_waddr   <= '0;
      r_data    <= '0;
      r_mem_out <= '0;
      r_addr_o  <= '0;
      r_dq_o    <= '0;
      r_oe      <= 1'b0;
      r_we_n    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          r_state  <= ST_LO;
          r_cnt    <= 4'd0;
          r_wr     <= MEM_W_EN;
          r_waddr  <= ALU_res[SRAM_ADDR_W:2];
          r_data   <= Val_Rm;
          r_addr_o <= {ALU_res[SRAM_ADDR_W:2], 1'b0};
          r_dq_o   <= MEM_W_EN ? Val_Rm[SRAM_DW-1:0] : '0;
          r_oe     <= MEM_W_EN;
          r_we_n   <= !(MEM_W_EN && LAST != 4'd0);
        end
        ST_LO: if (w_last) begin
          r_state  <= ST_HI;
          r_cnt    <= 4'd0;
          if (!r_wr) r_mem_out[SRAM_DW-1:0] <= sram_dq_i;
          r_addr_o <= {r_waddr, 1'b1};
          r_dq_o   <= r_wr ? r_data[WORD_WIDTH-1:SRAM_DW] : '0;
          r_we_n   <= !(r_wr && LAST != 4'd0);
        end else begin
          r_cnt  <= w_cnt_nx;
          r_we_n <= !(r_wr && w_cnt_nx != LAST);
        end
        ST_HI: if (w_last) begin
          r_state <= ST_DONE;
          r_cnt   <= 4'd0;
          if (!r_wr) r_mem_out[WORD_WIDTH-1:SRAM_DW] <= sram_dq_i;
          r_dq_o  <= '0;
          r_oe    <= 1'b0;
          r_we_n  <= 1'b1;
        end else begin
          r_cnt  <= w_cnt_nx;
          r_we_n <= !(r_wr && w_cnt_nx != LAST);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  logic r_mis;
  logic r_err;
  assign err = r_err;
  // err is high exactly while in DONE for an access whose byte offset was nonzero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_req) r_mis <= |ALU_res[1:0];
      r_err <= r_state == ST_HI && w_last && r_mis;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with a 16-bit SRAM model (WAIT_CYCLES=2).
module tb_sram_ctrl;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] ALU_res = '0;
  logic [31:0] Val_Rm = '0;
  logic        ready;
  logic [31:0] MEM_out;
  logic        err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;
  sram_ctrl #(.WAIT_CYCLES(2), .SRAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_res(ALU_res), .Val_Rm(Val_Rm), .ready(ready), .MEM_out(MEM_out), .err(err),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [0:(1<<18)-1];
  assign sram_dq_i = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  typedef struct { logic [31:0] mem_out; int stall; logic err; int gap; } done_t;
  typedef struct { logic [17:0] addr; logic [15:0] data; } wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [31:0] exp_mem = '0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Monitor: pops an SRAM write record per we_n-low cycle and a completion record per stall end.
  done_t d;
  wr_t   w;
  bit    prev_ready = 1'b1;
  int    hi_run = 0;
  int    stall = 0;
  int    gap = 0;
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (!sram_we_n) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL wr_extra: write addr %h data %h expected none at %0t", sram_addr, sram_dq_o, $time);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(sram_addr), 32'(w.addr));
          check("wr_data", 32'(sram_dq_o), 32'(w.data));
          check("wr_oe", 32'(sram_dq_oe), 32'd1);
        end
      end
      if (!ready) begin
        if (prev_ready) begin
          gap = hi_run;
          stall = 0;
        end
        stall++;
        check("err_stall", 32'(err), 32'd0);
      end else begin
        if (!prev_ready) begin
          if (done_q.size() == 0) begin
            n_checks++;
            $display("FAIL done_extra: completion after %0d stall cycles expected none at %0t", stall, $time);
          end else begin
            d = done_q.pop_front();
            check("mem_out", MEM_out, d.mem_out);
            check("stall_len", 32'(stall), 32'(d.stall));
            check("err_done", 32'(err), 32'(d.err));
            check("done_we_n", 32'(sram_we_n), 32'd1);
            check("done_oe", 32'(sram_dq_oe), 32'd0);
            check("done_dq_o", 32'(sram_dq_o), 32'd0);
            if (d.gap >= 0) check("gap", 32'(gap), 32'(d.gap));
          end
          hi_run = 0;
        end
        hi_run++;
      end
      prev_ready = ready;
    end
  end
  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 40);
    if (!ready) begin
      n_checks++;
      $display("FAIL timeout: ready stuck 0 after %0d cycles expected 1", k);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] dat, input logic [17:0] ha, input logic both);
    wr_q.push_back('{ha, dat[15:0]});
    wr_q.push_back('{ha + 18'd1, dat[31:16]});
    done_q.push_back('{exp_mem, 5, ALIGN && a[1:0] != 2'b00, -1});
    @(posedge clk); #1;
    MEM_R_EN = both; MEM_W_EN = 1'b1; ALU_res = a; Val_Rm = dat;
    wait_done();
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] dat);
    exp_mem = dat;
    done_q.push_back('{dat, 5, 1'b0, -1});
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; ALU_res = a;
    wait_done();
    MEM_R_EN = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_idle", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_mem_out", MEM_out, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    mon_en = 1'b1;
    wr(32'h0000_0400, 32'hDEAD_BEEF, 18'h200, 1'b0);
    rd(32'h0000_0400, 32'hDEAD_BEEF);
    wr(32'h0000_0010, 32'h1234_5678, 18'h008, 1'b0);
    rd(32'h0000_0010, 32'h1234_5678);
    wr(32'h0008_0404, 32'hCAFE_F00D, 18'h202, 1'b0);
    rd(32'h0000_0404, 32'hCAFE_F00D);
    wr(32'h0000_0020, 32'hA5A5_5A5A, 18'h010, 1'b1);
    done_q.push_back('{32'hDEAD_BEEF, 5, 1'b0, -1});
    done_q.push_back('{32'hA5A5_5A5A, 5, 1'b0, 1});
    @(posedge clk); #1;
    MEM_R_EN = 1'b1; ALU_res = 32'h0000_0400;
    wait_done();
    ALU_res = 32'h0000_0020;
    wait_done();
    MEM_R_EN = 1'b0;
    exp_mem = 32'hA5A5_5A5A;
    wr(32'h0000_0402, 32'h0BAD_CAFE, 18'h200, 1'b0);
    wr_q.push_back('{18'h020, 16'h2222});
    done_q.push_back('{32'h0, 3, 1'b0, -1});
    @(posedge clk); #1;
    MEM_W_EN = 1'b1; ALU_res = 32'h0000_0040; Val_Rm = 32'h1111_2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mem = 32'h0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    rd(32'h0000_0040, 32'h0000_2222);
    repeat (5) @(negedge clk);
    check("done_q_empty", 32'(done_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
